uart_rx_os: RTL and testbench
=============================

Name: uart_rx_os

Overview:
Parametrised oversampling UART receiver. It is the successor to the current 1x-clocked receiver and replaces its combinational start/parity/stop checkers with a single sequential datapath. It has configurable data width, oversampling ratio and a runtime parity mode. It sits between the serial line and the host side, and takes its sampling enable from the existing rx baud generator.

Parameters:
- DATA_BITS, 8, number of data bits per frame; legal range 5..9; sent LSB first.
- OVERSAMPLE, 16, baud_tick pulses per bit period; must be even and at least 4.

Ports:
- clock, input, 1, system clock; all logic is on the rising edge.
- reset, input, 1, asynchronous, active-high reset.
- baud_tick, input, 1, single-cycle sample enable at OVERSAMPLE x the baud rate.
- rx_data, input, 1, asynchronous serial line; idles high.
- parity_mode, input, 2, 00 = none, 01 = even, 10 = odd, 11 = none. Sampled only in IDLE when a start edge is detected.
- data_output, output, DATA_BITS, last received word; held until the next data_valid.
- data_valid, output, 1, one-clock pulse when a frame completes.
- parity_error, output, 1, status of the last frame; updated with data_valid.
- stop_bit_error, output, 1, framing error of the last frame; updated with data_valid.
- busy, output, 1, high from start-edge detection until the FSM re-enters IDLE.

Behaviour:
- Reset (asynchronous, active-high):
  - data_output=0, data_valid=0, parity_error=0, stop_bit_error=0, busy=0.
  - Synchroniser flops reset to 1. FSM goes to IDLE. Counters go to 0.
- rx_data passes through a 2-flop synchroniser before any use, giving 2 clocks of input latency.
- Counters: tick_cnt is $clog2(OVERSAMPLE) bits and bit_cnt is $clog2(DATA_BITS+1) bits. Both advance only on baud_tick and wrap to 0 explicitly, never by overflow.
- FSM states and transitions:
  - IDLE: on a baud_tick with rx_sync=0, go to START, clear tick_cnt, set busy, latch parity_mode.
  - START: at tick_cnt=OVERSAMPLE/2-1, sample the bit-centre.
    - Sample 0: go to DATA and clear tick_cnt.
    - Sample 1 (false start/glitch): go back to IDLE, clear busy, no data_valid.
  - DATA: each time tick_cnt reaches OVERSAMPLE-1, sample into shift register bit position bit_cnt (LSB first) and increment bit_cnt. After DATA_BITS samples, go to PARITY if the latched mode is even or odd, otherwise go to STOP.
  - PARITY: sample at OVERSAMPLE-1.
    - Even: error if the sample differs from the XOR of the data.
    - Odd: error if the sample equals the XOR of the data.
    - Always proceeds to STOP; the frame is never aborted on a parity error.
  - STOP: sample at OVERSAMPLE-1.
    - Load data_output and both error flags, and pulse data_valid on the following clock.
    - Stop sample 1: go to IDLE.
    - Stop sample 0: set stop_bit_error and go to BREAK.
  - BREAK: stay until a baud_tick sees rx_sync=1, then go to IDLE. A held-low line (break) must not retrigger reception.
- Latency: data_valid rises exactly 1 clock after the baud_tick that samples the stop bit.
- A start edge arriving on the baud_tick immediately after a good stop bit is accepted, so back-to-back frames are supported.
- Error flags stay sticky until the next data_valid. They are not cleared by a new start edge.
- Reset mid-frame: the frame is discarded, no data_valid is issued, and all outputs return to their reset values.
- baud_tick held low freezes the FSM and counters. No timeout.

Optional Feature:
- Macro: UART_RX_MAJORITY_EN.
- Defined: each bit value (start, data, parity, stop) is the 2-of-3 majority of rx_sync on the three consecutive baud_ticks ending at the nominal centre sample, i.e. tick_cnt = centre-2, centre-1 and centre.
- Not defined: a single sample at the centre tick.
- Timing and latency are identical in both builds.

Decomposition:
- Package uart_pkg holds:
  - parity-mode constants PAR_NONE, PAR_EVEN, PAR_ODD;
  - the rx state enum (IDLE, START, DATA, PARITY, STOP, BREAK).
- One sub-module, uart_rx_sync, contains:
  - the 2-flop synchroniser;
  - the majority-vote sampler under UART_RX_MAJORITY_EN.
- The FSM, counters and shift register stay in uart_rx_os.

Test Plan:
Setup: DATA_BITS=8, OVERSAMPLE=16, baud_tick every 4 clocks. Each case is run with and without UART_RX_MAJORITY_EN.
- parity_mode=00, frame 0xA5 8N1 → single data_valid pulse, data_output=0xA5, both errors 0, busy falls after the stop bit.
- parity_mode=01, frame 0x5B with parity bit 1 → parity_error=0. Same data with parity bit 0 → data_output=0x5B and parity_error=1.
- rx_data low for 4 ticks in IDLE → no data_valid, busy pulses then returns to 0. A following clean frame 0x3C is received correctly.
- Frame 0x3C with stop bit 0, then line held low for 3 bit times → data_valid with stop_bit_error=1 and no further data_valid until the line goes high. The next frame 0x81 arrives with stop_bit_error=0.
- reset asserted mid-DATA (after 4 bits) → outputs at reset values immediately, no data_valid. A following frame 0x81 is received correctly.
- Back-to-back frames 0x00 then 0xFF with no idle gap → two data_valid pulses 10 bit times apart, values 0x00 and 0xFF, no errors.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants and state encoding for the oversampling UART receiver
//
// Purpose: parity-mode encodings and the receiver state enum used by uart_rx_os.
// Ports:   none (package).
package uart_pkg;

  // parity_mode encodings; 2'b11 is treated the same as PAR_NONE.
  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } rx_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - serial line synchroniser and bit-value sampler
//
// Purpose: brings rx_data into the clock domain through two flops and
//          produces the value the FSM uses at a bit-centre sample.
//          With UART_RX_MAJORITY_EN defined, rx_bit is the 2-of-3 majority of
//          rx_sync on the previous two baud ticks and the current one;
//          otherwise rx_bit is rx_sync itself.
// Ports:
//   clock     in   system clock
//   reset     in   asynchronous active-high reset
//   baud_tick in   oversampling sample enable
//   rx_data   in   asynchronous serial line (idles high)
//   rx_sync   out  synchronised line level
//   rx_bit    out  bit value to use when the FSM samples on a baud_tick
module uart_rx_sync
  import uart_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic baud_tick,
  input  logic rx_data,
  output logic rx_sync,
  output logic rx_bit
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = rx_data;
    sync_d = meta_q;
  end

  // Reset to the idle line level so no start edge is seen out of reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign rx_sync = sync_q;

`ifdef UART_RX_MAJORITY_EN
  // hist_q[0] = sample from the previous tick, hist_q[1] = the one before.
  // On the centre tick these are centre-1 and centre-2, sync_q is centre.
  logic [1:0] hist_q, hist_d;

  always_comb begin
    hist_d = hist_q;
    if (baud_tick) hist_d = {hist_q[0], sync_q};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) hist_q <= 2'b11;
    else       hist_q <= hist_d;
  end

  assign rx_bit = (hist_q[1] & hist_q[0]) |
                  (hist_q[1] & sync_q)    |
                  (hist_q[0] & sync_q);
`else
  logic unused_baud_tick;
  assign unused_baud_tick = baud_tick;
  assign rx_bit           = sync_q;
`endif

endmodule

// File: rtl/uart_rx_os.sv
// rtl/uart_rx_os.sv - parametrised oversampling UART receiver
//
// Purpose: receives start / DATA_BITS data (LSB first) / optional parity /
//          stop frames, sampling each bit at its centre on baud_tick.
//          Optional 2-of-3 majority sampling via UART_RX_MAJORITY_EN
//          (implemented in uart_rx_sync; timing is identical either way).
// Parameters:
//   DATA_BITS   data bits per frame (5..9)
//   OVERSAMPLE  baud_tick pulses per bit (even, >= 4)
// Ports:
//   clock          in   system clock
//   reset          in   asynchronous active-high reset
//   baud_tick      in   sample enable at OVERSAMPLE x baud
//   rx_data        in   serial line (idles high)
//   parity_mode    in   00/11 none, 01 even, 10 odd; latched at start edge
//   data_output    out  last received word
//   data_valid     out  one-clock pulse per completed frame
//   parity_error   out  parity status of the last frame
//   stop_bit_error out  framing status of the last frame
//   busy           out  high from start-edge detection until back in IDLE
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 baud_tick,
  input  logic                 rx_data,
  input  logic [1:0]           parity_mode,
  output logic [DATA_BITS-1:0] data_output,
  output logic                 data_valid,
  output logic                 parity_error,
  output logic                 stop_bit_error,
  output logic                 busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] TICK_MID = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_END = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

  logic rx_sync;
  logic rx_bit;

  uart_rx_sync u_sync (
    .clock     (clock),
    .reset     (reset),
    .baud_tick (baud_tick),
    .rx_data   (rx_data),
    .rx_sync   (rx_sync),
    .rx_bit    (rx_bit)
  );

  rx_state_e            state_q, state_d;
  logic [TW-1:0]        tick_q, tick_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [1:0]           mode_q, mode_d;
  logic                 perr_pend_q, perr_pend_d;
  logic [DATA_BITS-1:0] data_output_q, data_output_d;
  logic                 data_valid_q, data_valid_d;
  logic                 parity_error_q, parity_error_d;
  logic                 stop_bit_error_q, stop_bit_error_d;
  logic                 busy_q, busy_d;

  always_comb begin
    state_d          = state_q;
    tick_d           = tick_q;
    bit_d            = bit_q;
    shift_d          = shift_q;
    mode_d           = mode_q;
    perr_pend_d      = perr_pend_q;
    data_output_d    = data_output_q;
    data_valid_d     = 1'b0;
    parity_error_d   = parity_error_q;
    stop_bit_error_d = stop_bit_error_q;
    busy_d           = busy_q;

    // Everything advances only on baud_tick; without it the FSM is frozen.
    if (baud_tick) begin
      case (state_q)
        IDLE: begin
          if (!rx_sync) begin
            state_d     = START;
            tick_d      = '0;
            bit_d       = '0;
            busy_d      = 1'b1;
            mode_d      = parity_mode;
            perr_pend_d = 1'b0;
          end
        end

        START: begin
          if (tick_q == TICK_MID) begin
            tick_d = '0;
            if (rx_bit) begin
              // Line went back high by mid-bit: glitch, not a start bit.
              state_d = IDLE;
              busy_d  = 1'b0;
            end else begin
              state_d = DATA;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end

        DATA: begin
          if (tick_q == TICK_END) begin
            tick_d = '0;
            for (int i = 0; i < DATA_BITS; i++) begin
              if (bit_q == BW'(i)) shift_d[i] = rx_bit;
            end
            if (bit_q == BIT_LAST) begin
              bit_d   = '0;
              state_d = (mode_q == PAR_EVEN || mode_q == PAR_ODD) ? PARITY : STOP;
            end else begin
              bit_d = bit_q + 1'b1;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end

        PARITY: begin
          if (tick_q == TICK_END) begin
            tick_d      = '0;
            perr_pend_d = (mode_q == PAR_ODD) ? (rx_bit == ^shift_q)
                                              : (rx_bit != ^shift_q);
            state_d     = STOP;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end

        STOP: begin
          if (tick_q == TICK_END) begin
            tick_d           = '0;
            data_output_d    = shift_q;
            parity_error_d   = perr_pend_q;
            stop_bit_error_d = ~rx_bit;
            data_valid_d     = 1'b1;
            // A low stop bit may be the start of a break; wait for idle.
            state_d          = rx_bit ? IDLE : BREAK;
            busy_d           = ~rx_bit;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end

        BREAK: begin
          if (rx_sync) begin
            state_d = IDLE;
            busy_d  = 1'b0;
          end
        end

        default: begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q          <= IDLE;
      tick_q           <= '0;
      bit_q            <= '0;
      shift_q          <= '0;
      mode_q           <= PAR_NONE;
      perr_pend_q      <= 1'b0;
      data_output_q    <= '0;
      data_valid_q     <= 1'b0;
      parity_error_q   <= 1'b0;
      stop_bit_error_q <= 1'b0;
      busy_q           <= 1'b0;
    end else begin
      state_q          <= state_d;
      tick_q           <= tick_d;
      bit_q            <= bit_d;
      shift_q          <= shift_d;
      mode_q           <= mode_d;
      perr_pend_q      <= perr_pend_d;
      data_output_q    <= data_output_d;
      data_valid_q     <= data_valid_d;
      parity_error_q   <= parity_error_d;
      stop_bit_error_q <= stop_bit_error_d;
      busy_q           <= busy_d;
    end
  end

  assign data_output    = data_output_q;
  assign data_valid     = data_valid_q;
  assign parity_error   = parity_error_q;
  assign stop_bit_error = stop_bit_error_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_uart_rx_os.sv
// tb/tb_uart_rx_os.sv - scoreboard bench for uart_rx_os
module tb_uart_rx_os;

  localparam int DATA_BITS  = 8;
  localparam int OVERSAMPLE = 16;
  localparam int TICK_DIV   = 4;
  localparam int BIT_CLKS   = OVERSAMPLE * TICK_DIV;

  logic                 clock;
  logic                 reset;
  logic                 baud_tick;
  logic                 rx_data;
  logic [1:0]           parity_mode;
  logic [DATA_BITS-1:0] data_output;
  logic                 data_valid;
  logic                 parity_error;
  logic                 stop_bit_error;
  logic                 busy;

  typedef struct {
    logic [7:0] data;
    logic       perr;
    logic       serr;
  } exp_t;

  typedef struct {
    logic [7:0] data;
    logic       perr;
    logic       serr;
    int         cyc;
  } obs_t;

  exp_t exp_q[$];
  obs_t rx_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  uart_rx_os #(.DATA_BITS(DATA_BITS), .OVERSAMPLE(OVERSAMPLE)) dut (
    .clock          (clock),
    .reset          (reset),
    .baud_tick      (baud_tick),
    .rx_data        (rx_data),
    .parity_mode    (parity_mode),
    .data_output    (data_output),
    .data_valid     (data_valid),
    .parity_error   (parity_error),
    .stop_bit_error (stop_bit_error),
    .busy           (busy)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Baud tick every TICK_DIV clocks, changed on the falling edge.
  initial begin
    int div;
    div       = 0;
    baud_tick = 1'b0;
    forever begin
      @(negedge clock);
      baud_tick = (div == 0);
      div       = (div + 1) % TICK_DIV;
    end
  end

  // Captures every data_valid cycle together with its cycle number.
  initial begin
    obs_t o;
    forever begin
      @(negedge clock);
      cyc++;
      if (data_valid === 1'b1) begin
        o.data = data_output;
        o.perr = parity_error;
        o.serr = stop_bit_error;
        o.cyc  = cyc;
        rx_q.push_back(o);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic model_perr(input logic [1:0] m, input logic [7:0] d, input logic pb);
    case (m)
      2'b01:   return pb != ^d;
      2'b10:   return pb == ^d;
      default: return 1'b0;
    endcase
  endfunction

  function automatic exp_t mk_exp(input logic [7:0] d, input logic pe, input logic se);
    exp_t e;
    e.data = d;
    e.perr = pe;
    e.serr = se;
    return e;
  endfunction

  task automatic hold(input logic b, input int bits);
    rx_data = b;
    repeat (bits * BIT_CLKS) @(negedge clock);
  endtask

  task automatic send_tail(input logic [7:0] d, input bit par_en, input logic pb, input logic sb);
    for (int i = 0; i < 8; i++) hold(d[i], 1);
    if (par_en) hold(pb, 1);
    hold(sb, 1);
  endtask

  task automatic send_frame(input logic [7:0] d, input bit par_en, input logic pb, input logic sb);
    hold(1'b0, 1);
    send_tail(d, par_en, pb, sb);
  endtask

  task automatic wait_frames(input int n);
    int budget;
    budget = 4 * BIT_CLKS;
    while (rx_q.size() < n && budget > 0) begin
      @(negedge clock);
      budget--;
    end
  endtask

  task automatic test_reset();
    reset       = 1'b1;
    rx_data     = 1'b1;
    parity_mode = 2'b00;
    repeat (3) @(negedge clock);
    n_tests++; if (data_output !== 8'h00) begin n_fail++; $display("FAIL reset data_output: got %h want 00", data_output); end
    n_tests++; if (data_valid !== 1'b0) begin n_fail++; $display("FAIL reset data_valid: got %b want 0", data_valid); end
    n_tests++; if (parity_error !== 1'b0) begin n_fail++; $display("FAIL reset parity_error: got %b want 0", parity_error); end
    n_tests++; if (stop_bit_error !== 1'b0) begin n_fail++; $display("FAIL reset stop_bit_error: got %b want 0", stop_bit_error); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset busy: got %b want 0", busy); end
    reset = 1'b0;
    hold(1'b1, 1);
  endtask

  task automatic test_8n1();
    exp_t e;
    obs_t r;
    parity_mode = 2'b00;
    exp_q.push_back(mk_exp(8'hA5, 1'b0, 1'b0));
    hold(1'b0, 1);
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL 8n1 busy in frame: got %b want 1", busy); end
    send_tail(8'hA5, 1'b0, 1'b0, 1'b1);
    hold(1'b1, 1);
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL 8n1 busy after stop: got %b want 0", busy); end
    wait_frames(exp_q.size());
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n_tests++;
      if (rx_q.size() == 0) begin
        n_fail++; $display("FAIL 8n1 frame: no data_valid, want data=%h perr=%b serr=%b", e.data, e.perr, e.serr);
      end else begin
        r = rx_q.pop_front();
        if ({r.data, r.perr, r.serr} !== {e.data, e.perr, e.serr}) begin
          n_fail++; $display("FAIL 8n1 frame: got data=%h perr=%b serr=%b want data=%h perr=%b serr=%b", r.data, r.perr, r.serr, e.data, e.perr, e.serr);
        end
      end
    end
    n_tests++; if (rx_q.size() != 0) begin n_fail++; $display("FAIL 8n1 extra data_valid: got %0d want 0", rx_q.size()); rx_q.delete(); end
  endtask

  task automatic test_parity();
    exp_t e;
    obs_t r;
    parity_mode = 2'b01;
    exp_q.push_back(mk_exp(8'h5B, model_perr(2'b01, 8'h5B, 1'b1), 1'b0));
    send_frame(8'h5B, 1'b1, 1'b1, 1'b1);
    hold(1'b1, 1);
    exp_q.push_back(mk_exp(8'h5B, model_perr(2'b01, 8'h5B, 1'b0), 1'b0));
    send_frame(8'h5B, 1'b1, 1'b0, 1'b1);
    hold(1'b1, 1);
    parity_mode = 2'b10;
    exp_q.push_back(mk_exp(8'h5B, model_perr(2'b10, 8'h5B, 1'b0), 1'b0));
    hold(1'b0, 1);
    n_tests++; if (parity_error !== 1'b1) begin n_fail++; $display("FAIL parity sticky over start: got %b want 1", parity_error); end
    send_tail(8'h5B, 1'b1, 1'b0, 1'b1);
    hold(1'b1, 1);
    exp_q.push_back(mk_exp(8'hC3, model_perr(2'b10, 8'hC3, 1'b0), 1'b0));
    send_frame(8'hC3, 1'b1, 1'b0, 1'b1);
    hold(1'b1, 1);
    parity_mode = 2'b11;
    exp_q.push_back(mk_exp(8'h3C, 1'b0, 1'b0));
    send_frame(8'h3C, 1'b0, 1'b0, 1'b1);
    hold(1'b1, 1);
    wait_frames(exp_q.size());
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n_tests++;
      if (rx_q.size() == 0) begin
        n_fail++; $display("FAIL parity frame: no data_valid, want data=%h perr=%b serr=%b", e.data, e.perr, e.serr);
      end else begin
        r = rx_q.pop_front();
        if ({r.data, r.perr, r.serr} !== {e.data, e.perr, e.serr}) begin
          n_fail++; $display("FAIL parity frame: got data=%h perr=%b serr=%b want data=%h perr=%b serr=%b", r.data, r.perr, r.serr, e.data, e.perr, e.serr);
        end
      end
    end
    n_tests++; if (rx_q.size() != 0) begin n_fail++; $display("FAIL parity extra data_valid: got %0d want 0", rx_q.size()); rx_q.delete(); end
  endtask

  task automatic test_false_start();
    exp_t e;
    obs_t r;
    parity_mode = 2'b00;
    rx_data = 1'b0;
    repeat (12) @(negedge clock);
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL glitch busy rise: got %b want 1", busy); end
    repeat (4) @(negedge clock);
    hold(1'b1, 2);
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL glitch busy fall: got %b want 0", busy); end
    n_tests++; if (rx_q.size() != 0) begin n_fail++; $display("FAIL glitch data_valid: got %0d pulses want 0", rx_q.size()); rx_q.delete(); end
    exp_q.push_back(mk_exp(8'h3C, 1'b0, 1'b0));
    send_frame(8'h3C, 1'b0, 1'b0, 1'b1);
    hold(1'b1, 1);
    wait_frames(exp_q.size());
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n_tests++;
      if (rx_q.size() == 0) begin
        n_fail++; $display("FAIL glitch frame: no data_valid, want data=%h", e.data);
      end else begin
        r = rx_q.pop_front();
        if ({r.data, r.perr, r.serr} !== {e.data, e.perr, e.serr}) begin
          n_fail++; $display("FAIL glitch frame: got data=%h perr=%b serr=%b want data=%h perr=%b serr=%b", r.data, r.perr, r.serr, e.data, e.perr, e.serr);
        end
      end
    end
  endtask

  task automatic test_break();
    exp_t e;
    obs_t r;
    parity_mode = 2'b00;
    exp_q.push_back(mk_exp(8'h3C, 1'b0, 1'b1));
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    hold(1'b0, 3);
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL break busy held: got %b want 1", busy); end
    wait_frames(exp_q.size());
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n_tests++;
      if (rx_q.size() == 0) begin
        n_fail++; $display("FAIL break frame: no data_valid, want data=%h serr=%b", e.data, e.serr);
      end else begin
        r = rx_q.pop_front();
        if ({r.data, r.perr, r.serr} !== {e.data, e.perr, e.serr}) begin
          n_fail++; $display("FAIL break frame: got data=%h perr=%b serr=%b want data=%h perr=%b serr=%b", r.data, r.perr, r.serr, e.data, e.perr, e.serr);
        end
      end
    end
    n_tests++; if (rx_q.size() != 0) begin n_fail++; $display("FAIL break retrigger: got %0d extra pulses want 0", rx_q.size()); rx_q.delete(); end
    hold(1'b1, 1);
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL break busy release: got %b want 0", busy); end
    n_tests++; if (stop_bit_error !== 1'b1) begin n_fail++; $display("FAIL break serr sticky: got %b want 1", stop_bit_error); end
    exp_q.push_back(mk_exp(8'h81, 1'b0, 1'b0));
    send_frame(8'h81, 1'b0, 1'b0, 1'b1);
    hold(1'b1, 1);
    wait_frames(exp_q.size());
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n_tests++;
      if (rx_q.size() == 0) begin
        n_fail++; $display("FAIL break recovery: no data_valid, want data=%h", e.data);
      end else begin
        r = rx_q.pop_front();
        if ({r.data, r.perr, r.serr} !== {e.data, e.perr, e.serr}) begin
          n_fail++; $display("FAIL break recovery: got data=%h perr=%b serr=%b want data=%h perr=%b serr=%b", r.data, r.perr, r.serr, e.data, e.perr, e.serr);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    obs_t r;
    parity_mode = 2'b00;
    hold(1'b0, 1);
    for (int i = 0; i < 4; i++) hold(i[0], 1);
    reset   = 1'b1;
    rx_data = 1'b1;
    #1;
    n_tests++; if (data_output !== 8'h00) begin n_fail++; $display("FAIL midreset data_output: got %h want 00", data_output); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midreset busy: got %b want 0", busy); end
    n_tests++; if (data_valid !== 1'b0) begin n_fail++; $display("FAIL midreset data_valid: got %b want 0", data_valid); end
    repeat (3) @(negedge clock);
    reset = 1'b0;
    hold(1'b1, 2);
    n_tests++; if (rx_q.size() != 0) begin n_fail++; $display("FAIL midreset data_valid: got %0d pulses want 0", rx_q.size()); rx_q.delete(); end
    exp_q.push_back(mk_exp(8'h81, 1'b0, 1'b0));
    send_frame(8'h81, 1'b0, 1'b0, 1'b1);
    hold(1'b1, 1);
    wait_frames(exp_q.size());
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n_tests++;
      if (rx_q.size() == 0) begin
        n_fail++; $display("FAIL midreset recovery: no data_valid, want data=%h", e.data);
      end else begin
        r = rx_q.pop_front();
        if ({r.data, r.perr, r.serr} !== {e.data, e.perr, e.serr}) begin
          n_fail++; $display("FAIL midreset recovery: got data=%h perr=%b serr=%b want data=%h perr=%b serr=%b", r.data, r.perr, r.serr, e.data, e.perr, e.serr);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    obs_t r;
    int   prev_cyc;
    parity_mode = 2'b00;
    prev_cyc    = -1;
    exp_q.push_back(mk_exp(8'h00, 1'b0, 1'b0));
    exp_q.push_back(mk_exp(8'hFF, 1'b0, 1'b0));
    send_frame(8'h00, 1'b0, 1'b0, 1'b1);
    send_frame(8'hFF, 1'b0, 1'b0, 1'b1);
    hold(1'b1, 1);
    wait_frames(exp_q.size());
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n_tests++;
      if (rx_q.size() == 0) begin
        n_fail++; $display("FAIL b2b frame: no data_valid, want data=%h", e.data);
      end else begin
        r = rx_q.pop_front();
        if ({r.data, r.perr, r.serr} !== {e.data, e.perr, e.serr}) begin
          n_fail++; $display("FAIL b2b frame: got data=%h perr=%b serr=%b want data=%h perr=%b serr=%b", r.data, r.perr, r.serr, e.data, e.perr, e.serr);
        end
        if (prev_cyc >= 0) begin
          n_tests++;
          if (r.cyc - prev_cyc != 10 * BIT_CLKS) begin
            n_fail++; $display("FAIL b2b spacing: got %0d clocks want %0d", r.cyc - prev_cyc, 10 * BIT_CLKS);
          end
        end
        prev_cyc = r.cyc;
      end
    end
    n_tests++; if (rx_q.size() != 0) begin n_fail++; $display("FAIL b2b extra data_valid: got %0d want 0", rx_q.size()); rx_q.delete(); end
  endtask

  initial begin
    reset       = 1'b1;
    rx_data     = 1'b1;
    parity_mode = 2'b00;
    @(negedge clock);
    test_reset();
    test_8n1();
    test_parity();
    test_false_start();
    test_break();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
